// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single VRAM port between display readout and the host.
// The display wins any cycle its window is open. Host writes are queued in a small FIFO.
// Host reads wait in a one-entry hold and return after a fixed latency.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          dispActive,
  input  logic [ADDR_W-1:0]             dispAddr,
  input  logic                          hostWrValid,
  output logic                          hostWrReady,
  input  logic [ADDR_W-1:0]             hostWrAddr,
  input  logic [DATA_W-1:0]             hostWrData,
  input  logic                          hostRdValid,
  output logic                          hostRdReady,
  input  logic [ADDR_W-1:0]             hostRdAddr,
  output logic                          hostRdDataValid,
  output logic [DATA_W-1:0]             hostRdData,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic [ADDR_W-1:0]             vramAddr,
  output logic                          vramWe,
  output logic [DATA_W-1:0]             vramWData,
  input  logic [DATA_W-1:0]             vramRData
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_DISP  = 2'd1,
    SLOT_WRITE = 2'd2,
    SLOT_READ  = 2'd3
  } slot_t;

  logic [ADDR_W-1:0]     fifoAddr [FIFO_DEPTH];
  logic [DATA_W-1:0]     fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic                  holdFull;
  logic [ADDR_W-1:0]     holdAddr;
  logic [RD_LATENCY-1:0] rdPipe;

  logic  fifoEmpty;
  logic  fifoFull;
  logic  wrPush;
  logic  rdAccept;
  logic  wrPop;
  logic  rdIssue;
  slot_t slot;

  // Occupancy flags and host handshakes; a held read blocks new writes to keep RAW ordering
  always_comb begin
    fifoEmpty   = (fifoLevel == '0);
    fifoFull    = (fifoLevel == LVL_W'(FIFO_DEPTH));
    hostWrReady = ~fifoFull & ~holdFull;
    hostRdReady = ~holdFull;
    wrPush      = hostWrValid & hostWrReady;
    rdAccept    = hostRdValid & hostRdReady;
  end

  // Slot owner this cycle: display, then pending writes, then the held read
  always_comb begin
    slot = SLOT_IDLE;
    if (dispActive) begin
      slot = SLOT_DISP;
    end else if (!fifoEmpty) begin
      slot = SLOT_WRITE;
    end else if (holdFull) begin
      slot = SLOT_READ;
    end
    wrPop   = (slot == SLOT_WRITE);
    rdIssue = (slot == SLOT_READ);
  end

  // VRAM port drive for the selected slot
  always_comb begin
    vramAddr  = '0;
    vramWe    = 1'b0;
    vramWData = '0;
    case (slot)
      SLOT_DISP: begin
        vramAddr = dispAddr;
      end
      SLOT_WRITE: begin
        vramAddr  = fifoAddr[rdPtr];
        vramWData = fifoData[rdPtr];
        vramWe    = 1'b1;
      end
      SLOT_READ: begin
        vramAddr = holdAddr;
      end
      default: begin
        vramAddr = '0;
      end
    endcase
  end

  // Write FIFO storage; contents need no reset since the level gates every use
  always_ff @(posedge clk) begin
    if (wrPush) begin
      fifoAddr[wrPtr] <= hostWrAddr;
      fifoData[wrPtr] <= hostWrData;
    end
  end

  // Write FIFO pointers and level; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoLevel <= '0;
    end else begin
      if (wrPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (wrPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({wrPush, wrPop})
        2'b10:   fifoLevel <= fifoLevel + LVL_W'(1);
        2'b01:   fifoLevel <= fifoLevel - LVL_W'(1);
        default: fifoLevel <= fifoLevel;
      endcase
    end
  end

  // Single-entry read hold: filled on accept, emptied when the read drives VRAM
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      holdFull <= 1'b0;
      holdAddr <= '0;
    end else if (rdAccept) begin
      holdFull <= 1'b1;
      holdAddr <= hostRdAddr;
    end else if (rdIssue) begin
      holdFull <= 1'b0;
    end
  end

  // Read-valid shift register tracking issued reads until VRAM data is ready
  generate
    if (RD_LATENCY > 1) begin : gPipeLong
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          rdPipe <= '0;
        end else begin
          rdPipe <= {rdPipe[RD_LATENCY-2:0], rdIssue};
        end
      end
    end else begin : gPipeShort
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          rdPipe <= '0;
        end else begin
          rdPipe <= rdIssue;
        end
      end
    end
  endgenerate

  // Return capture: data held until the next return, valid is a single-cycle pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hostRdDataValid <= 1'b0;
      hostRdData      <= '0;
    end else begin
      hostRdDataValid <= rdPipe[RD_LATENCY-1];
      if (rdPipe[RD_LATENCY-1]) begin
        hostRdData <= vramRData;
      end
    end
  end

endmodule
